// File: rtl/dice_roll_sequencer.sv
// Dice-roll turn sequencer: arms on a clear tray, confirms a colour,
// issues one roll pulse per turn and alternates players.
module dice_roll_sequencer #(
    parameter int CLEAR_CYCLES   = 1_000_000,
    parameter int CONFIRM_COUNT  = 3,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       result_ready,
    input  logic [1:0] stable_color,
    input  logic       white_stable,
    input  logic       turn_done,
    input  logic       winner_valid,
    output logic       roll_valid,
    output logic [1:0] roll_value,
    output logic       turn,
    output logic       armed,
    output logic       timeout_pulse,
    output logic [2:0] seq_state
);

    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    CNF_TGT  = 5'(CONFIRM_COUNT);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_CLEAR = 3'd1,
        ARMED      = 3'd2,
        CONFIRM    = 3'd3,
        ISSUE      = 3'd4,
        WAIT_DONE  = 3'd5,
        GAME_OVER  = 3'd6
    } state_t;

    state_t        state;
    logic [CW-1:0] clr_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    cnf_cnt;
    logic [1:0]    candidate;
    logic [4:0]    cnf_inc;

    // One more matching sample, widened so the target compare cannot wrap
    assign cnf_inc   = {1'b0, cnf_cnt} + 5'd1;
    assign seq_state = state;

    // Turn FSM with counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            clr_cnt       <= '0;
            to_cnt        <= '0;
            cnf_cnt       <= '0;
            candidate     <= '0;
            roll_valid    <= 1'b0;
            roll_value    <= '0;
            turn          <= 1'b0;
            armed         <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            roll_valid    <= 1'b0;
            timeout_pulse <= 1'b0;
            if (winner_valid && state != IDLE && state != GAME_OVER) begin
                // A winner beats any turn_done or pending roll this cycle
                state <= GAME_OVER;
                armed <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_btn) begin
                            state   <= WAIT_CLEAR;
                            turn    <= 1'b0;
                            clr_cnt <= '0;
                        end
                    end
                    WAIT_CLEAR: begin
                        if (!white_stable) begin
                            clr_cnt <= '0;
                        end else if (clr_cnt == CLR_LAST) begin
                            state   <= ARMED;
                            armed   <= 1'b1;
                            to_cnt  <= '0;
                            cnf_cnt <= '0;
                        end else if (clr_cnt != '1) begin
                            clr_cnt <= clr_cnt + CW'(1);
                        end
                    end
                    ARMED, CONFIRM: begin
                        if (to_cnt != '1)
                            to_cnt <= to_cnt + TW'(1);
                        if (to_cnt == TO_LAST) begin
                            // Abandon the roll; the same player tries again
                            state         <= WAIT_CLEAR;
                            armed         <= 1'b0;
                            timeout_pulse <= 1'b1;
                            clr_cnt       <= '0;
                            cnf_cnt       <= '0;
                        end else if (result_ready) begin
                            if (white_stable) begin
                                if (state == CONFIRM) begin
                                    cnf_cnt <= '0;
                                    state   <= ARMED;
                                end
                            end else if (state == ARMED) begin
                                candidate <= stable_color;
                                cnf_cnt   <= 4'd1;
                                if (CONFIRM_COUNT == 1) begin
                                    state      <= ISSUE;
                                    armed      <= 1'b0;
                                    roll_valid <= 1'b1;
                                    roll_value <= stable_color;
                                end else begin
                                    state <= CONFIRM;
                                end
                            end else if (stable_color == candidate) begin
                                cnf_cnt <= cnf_inc[3:0];
                                if (cnf_inc >= CNF_TGT) begin
                                    state      <= ISSUE;
                                    armed      <= 1'b0;
                                    roll_valid <= 1'b1;
                                    roll_value <= candidate;
                                end
                            end else begin
                                // Colour changed: restart confirmation on it
                                candidate <= stable_color;
                                cnf_cnt   <= 4'd1;
                            end
                        end
                    end
                    ISSUE: begin
                        state <= WAIT_DONE;
                    end
                    WAIT_DONE: begin
                        if (turn_done) begin
                            turn    <= ~turn;
                            state   <= WAIT_CLEAR;
                            clr_cnt <= '0;
                        end
                    end
                    GAME_OVER: begin
                        if (start_btn && !winner_valid) begin
                            state   <= WAIT_CLEAR;
                            turn    <= 1'b0;
                            clr_cnt <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        armed <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
